// File: rtl/regfile_param_pkg.sv
// rtl/regfile_param_pkg.sv - shared types and default sizes for the parametrised register file
package regfile_param_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_t;

   localparam int RF_WIDTH = 16;
   localparam int RF_DEPTH = 16;

endpackage

// File: rtl/regfile_param_clr_seq.sv
// rtl/regfile_param_clr_seq.sv - clear sequencer: walks cnt over every entry while busy
module regfile_param_clr_seq
   import regfile_param_pkg::*;
#(
   parameter int  DEPTH        = RF_DEPTH,
   parameter bit  CLR_ON_RESET = 1'b1,
   localparam int ABITS        = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   output logic             busy,
   output logic [ABITS-1:0] cnt,
   output logic             clr_we
);

   clr_state_t state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= CLR_ON_RESET ? CLEAR : IDLE;
         busy  <= CLR_ON_RESET;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (clr) begin
                  state <= CLEAR;
                  busy  <= 1'b1;
                  cnt   <= '0;
               end
            end
            CLEAR: begin
               // clr is ignored here; the sweep always runs to the last entry
               cnt <= cnt + 1'b1;
               if (cnt == ABITS'(DEPTH - 1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign clr_we = busy;

endmodule

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - 2-read/1-write register file with zero register, bypass and clear engine
module regfile_param
   import regfile_param_pkg::*;
#(
   parameter int  WIDTH        = RF_WIDTH,
   parameter int  DEPTH        = RF_DEPTH,
   parameter bit  ZERO_REG     = 1'b1,
   parameter bit  BYPASS       = 1'b0,
   parameter bit  CLR_ON_RESET = 1'b1,
   localparam int ABITS        = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             we3,
   input  logic [ABITS-1:0] wa3,
   input  logic [WIDTH-1:0] wd3,
   input  logic [ABITS-1:0] ra1,
   input  logic [ABITS-1:0] ra2,
   output logic [WIDTH-1:0] rd1,
   output logic [WIDTH-1:0] rd2,
   output logic             busy,
   output logic             wdrop
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [ABITS-1:0] cnt;
   logic             clr_we;
   logic             user_we;

   regfile_param_clr_seq #(
      .DEPTH        (DEPTH),
      .CLR_ON_RESET (CLR_ON_RESET)
   ) u_clr_seq (
      .clk    (clk),
      .reset  (reset),
      .clr    (clr),
      .busy   (busy),
      .cnt    (cnt),
      .clr_we (clr_we)
   );

   assign user_we = we3 && !busy && !(ZERO_REG && wa3 == '0);

   // The clear engine owns the write port while it runs
   always_ff @(posedge clk) begin
      if (clr_we)
         mem[cnt] <= '0;
      else if (user_we)
         mem[wa3] <= wd3;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         wdrop <= 1'b0;
      else
         wdrop <= we3 && busy;
   end

   assign rd1 = busy                          ? '0  :
                (ZERO_REG && ra1 == '0)       ? '0  :
                (BYPASS && we3 && ra1 == wa3) ? wd3 :
                                                mem[ra1];

   assign rd2 = busy                          ? '0  :
                (ZERO_REG && ra2 == '0)       ? '0  :
                (BYPASS && we3 && ra2 == wa3) ? wd3 :
                                                mem[ra2];

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - self-checking bench for regfile_param against a behavioural model
module tb_regfile_param;

   logic        clk = 1'b0;
   logic        reset;
   logic        clr, we3;
   logic [3:0]  wa3, ra1, ra2;
   logic [15:0] wd3;
   logic [15:0] rd1_a, rd2_a, rd1_b, rd2_b;
   logic        busy_a, wdrop_a, busy_b, wdrop_b;

   logic        clr_c, we3_c;
   logic [2:0]  wa3_c, ra1_c, ra2_c;
   logic [31:0] wd3_c, rd1_c, rd2_c;
   logic        busy_c, wdrop_c;

   int total = 0;
   int bad   = 0;

   logic [15:0] m16 [16];
   int          left16;
   bit          wd16;
   logic [31:0] m32 [8];
   int          left32;
   bit          wd32;

   always #5 clk = ~clk;

   regfile_param dut_a (
      .clk(clk), .reset(reset), .clr(clr), .we3(we3), .wa3(wa3), .wd3(wd3),
      .ra1(ra1), .ra2(ra2), .rd1(rd1_a), .rd2(rd2_a), .busy(busy_a), .wdrop(wdrop_a)
   );

   regfile_param #(.BYPASS(1'b1)) dut_b (
      .clk(clk), .reset(reset), .clr(clr), .we3(we3), .wa3(wa3), .wd3(wd3),
      .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b), .busy(busy_b), .wdrop(wdrop_b)
   );

   regfile_param #(.WIDTH(32), .DEPTH(8), .ZERO_REG(1'b0)) dut_c (
      .clk(clk), .reset(reset), .clr(clr_c), .we3(we3_c), .wa3(wa3_c), .wd3(wd3_c),
      .ra1(ra1_c), .ra2(ra2_c), .rd1(rd1_c), .rd2(rd2_c), .busy(busy_c), .wdrop(wdrop_c)
   );

   function automatic logic [15:0] exp16(input logic [3:0] ra, input bit byp);
      if (left16 > 0) return 16'h0;
      if (ra == 4'd0) return 16'h0;
      if (byp && we3 && ra == wa3) return wd3;
      return m16[ra];
   endfunction

   function automatic logic [31:0] exp32(input logic [2:0] ra);
      if (left32 > 0) return 32'h0;
      return m32[ra];
   endfunction

   task automatic model_after_reset();
      left16 = 16;
      left32 = 8;
      wd16   = 1'b0;
      wd32   = 1'b0;
      foreach (m16[i]) m16[i] = 16'h0;
      foreach (m32[i]) m32[i] = 32'h0;
   endtask

   // One clock edge; the model applies the rules to the inputs that were present at the edge
   task automatic tick();
      bit          w, c, wc, cc, b16, b32;
      logic [3:0]  a;
      logic [15:0] d;
      logic [2:0]  ac;
      logic [31:0] dc;
      w = we3; c = clr; a = wa3; d = wd3;
      wc = we3_c; cc = clr_c; ac = wa3_c; dc = wd3_c;
      b16 = (left16 > 0);
      b32 = (left32 > 0);
      @(posedge clk);
      #1;
      wd16 = w && b16;
      if (b16) left16--;
      else begin
         if (w && a != 4'd0) m16[a] = d;
         if (c) begin
            left16 = 16;
            foreach (m16[i]) m16[i] = 16'h0;
         end
      end
      wd32 = wc && b32;
      if (b32) left32--;
      else begin
         if (wc) m32[ac] = dc;
         if (cc) begin
            left32 = 8;
            foreach (m32[i]) m32[i] = 32'h0;
         end
      end
   endtask

   task automatic test_reset();
      int na, nc;
      reset = 1'b1;
      #2;
      total++;
      if (busy_a !== 1'b1 || wdrop_a !== 1'b0) begin
         bad++;
         $display("FAIL reset_state busy=%b wdrop=%b required busy=1 wdrop=0", busy_a, wdrop_a);
      end
      total++;
      if (rd1_a !== 16'h0 || rd2_c !== 32'h0) begin
         bad++;
         $display("FAIL reset_reads rd1=%h rd2_c=%h required 0", rd1_a, rd2_c);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      model_after_reset();
      na = 0; nc = 0;
      for (int k = 0; k < 20; k++) begin
         if (busy_a) na++;
         if (busy_c) nc++;
         tick();
      end
      total++;
      if (na != 16) begin
         bad++;
         $display("FAIL reset_busy_len got=%0d required=16", na);
      end
      total++;
      if (nc != 8) begin
         bad++;
         $display("FAIL reset_busy_len_wide got=%0d required=8", nc);
      end
      for (int i = 0; i < 16; i++) begin
         ra1 = 4'(i);
         ra2 = 4'(15 - i);
         #1;
         total++;
         if (rd1_a !== 16'h0 || rd2_a !== 16'h0 || rd1_b !== 16'h0) begin
            bad++;
            $display("FAIL cleared_read addr=%0d rd1=%h rd2=%h rd1_b=%h required 0", i, rd1_a, rd2_a, rd1_b);
         end
      end
   endtask

   task automatic test_write();
      we3 = 1'b1; wa3 = 4'd5; wd3 = 16'hBEEF;
      tick();
      we3 = 1'b0; ra1 = 4'd5; ra2 = 4'd5;
      #1;
      total++;
      if (rd1_a !== 16'hBEEF || rd2_a !== 16'hBEEF) begin
         bad++;
         $display("FAIL write_read rd1=%h rd2=%h required beef", rd1_a, rd2_a);
      end
      we3 = 1'b1; wa3 = 4'd0; wd3 = 16'h1234;
      tick();
      we3 = 1'b0; ra1 = 4'd0;
      #1;
      total++;
      if (rd1_a !== 16'h0 || wdrop_a !== 1'b0) begin
         bad++;
         $display("FAIL zero_reg rd1=%h wdrop=%b required rd1=0 wdrop=0", rd1_a, wdrop_a);
      end
   endtask

   task automatic test_bypass();
      we3 = 1'b1; wa3 = 4'd7; wd3 = 16'h0011;
      tick();
      wd3 = 16'h00A5; ra1 = 4'd7;
      #1;
      total++;
      if (rd1_a !== 16'h0011 || rd1_b !== 16'h00A5) begin
         bad++;
         $display("FAIL bypass_pre nobyp=%h byp=%h required 0011/00a5", rd1_a, rd1_b);
      end
      tick();
      we3 = 1'b0;
      #1;
      total++;
      if (rd1_a !== 16'h00A5 || rd1_b !== 16'h00A5) begin
         bad++;
         $display("FAIL bypass_post nobyp=%h byp=%h required 00a5", rd1_a, rd1_b);
      end
   endtask

   task automatic test_clear_drop();
      int nb;
      for (int n = 1; n < 16; n++) begin
         we3 = 1'b1; wa3 = 4'(n); wd3 = 16'(16'h0101 * n);
         tick();
      end
      we3 = 1'b0;
      for (int n = 1; n < 16; n++) begin
         ra1 = 4'(n); ra2 = 4'(16 - n);
         #1;
         total++;
         if (rd1_a !== 16'(16'h0101 * n) || rd2_a !== exp16(ra2, 1'b0)) begin
            bad++;
            $display("FAIL fill_read addr=%0d rd1=%h rd2=%h", n, rd1_a, rd2_a);
         end
      end
      clr = 1'b1;
      tick();
      clr = 1'b0;
      nb = 0;
      for (int k = 1; k <= 20; k++) begin
         if (busy_a) nb++;
         we3 = (k == 3); wa3 = 4'd9; wd3 = 16'hFFFF;
         tick();
         if (k == 3 || k == 4) begin
            total++;
            if (wdrop_a !== (k == 3) || wdrop_a !== wd16) begin
               bad++;
               $display("FAIL wdrop_pulse cycle=%0d got=%b required=%b", k, wdrop_a, k == 3);
            end
         end
      end
      we3 = 1'b0;
      total++;
      if (nb != 16) begin
         bad++;
         $display("FAIL clr_busy_len got=%0d required=16", nb);
      end
      for (int i = 0; i < 16; i++) begin
         ra1 = 4'(i);
         #1;
         total++;
         if (rd1_a !== 16'h0) begin
            bad++;
            $display("FAIL after_clear addr=%0d got=%h required=0", i, rd1_a);
         end
      end
   endtask

   task automatic test_reset_abort();
      int nb;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         we3 = (k == 7); wa3 = 4'd3; wd3 = 16'h5555;
         tick();
      end
      we3 = 1'b0;
      total++;
      if (wdrop_a !== 1'b1 || busy_a !== 1'b1) begin
         bad++;
         $display("FAIL abort_pre wdrop=%b busy=%b required 1/1", wdrop_a, busy_a);
      end
      reset = 1'b1;
      #1;
      total++;
      if (wdrop_a !== 1'b0 || busy_a !== 1'b1) begin
         bad++;
         $display("FAIL async_reset wdrop=%b busy=%b required 0/1", wdrop_a, busy_a);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      model_after_reset();
      nb = 0;
      for (int k = 1; k <= 24; k++) begin
         if (busy_a) nb++;
         clr = (k == 4);
         tick();
      end
      clr = 1'b0;
      total++;
      if (nb != 16) begin
         bad++;
         $display("FAIL abort_busy_len got=%0d required=16", nb);
      end
   endtask

   task automatic test_wide();
      int nb;
      we3_c = 1'b1; wa3_c = 3'd0; wd3_c = 32'hDEADBEEF;
      tick();
      we3_c = 1'b0; ra1_c = 3'd0;
      #1;
      total++;
      if (rd1_c !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL wide_addr0 got=%h required=deadbeef", rd1_c);
      end
      clr_c = 1'b1;
      tick();
      clr_c = 1'b0;
      nb = 0;
      for (int k = 0; k < 12; k++) begin
         if (busy_c) nb++;
         tick();
      end
      total++;
      if (nb != 8 || rd1_c !== 32'h0) begin
         bad++;
         $display("FAIL wide_clear busy_len=%0d rd1=%h required 8/0", nb, rd1_c);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         we3   = ($urandom_range(0, 2) != 0);
         wa3   = 4'($urandom_range(0, 15));
         wd3   = 16'($urandom);
         ra1   = ($urandom_range(0, 3) == 0) ? wa3 : 4'($urandom_range(0, 15));
         ra2   = 4'($urandom_range(0, 15));
         clr   = ($urandom_range(0, 59) == 0);
         we3_c = ($urandom_range(0, 1) != 0);
         wa3_c = 3'($urandom_range(0, 7));
         wd3_c = $urandom;
         ra1_c = ($urandom_range(0, 3) == 0) ? wa3_c : 3'($urandom_range(0, 7));
         ra2_c = 3'($urandom_range(0, 7));
         clr_c = ($urandom_range(0, 59) == 0);
         #1;
         total++;
         if (rd1_a !== exp16(ra1, 1'b0) || rd2_a !== exp16(ra2, 1'b0) ||
             rd1_b !== exp16(ra1, 1'b1) || rd2_b !== exp16(ra2, 1'b1) ||
             busy_a !== (left16 > 0) || wdrop_a !== wd16) begin
            bad++;
            $display("FAIL rand16 cyc=%0d rd=%h/%h/%h/%h busy=%b wdrop=%b required %h/%h/%h/%h %b %b",
                     k, rd1_a, rd2_a, rd1_b, rd2_b, busy_a, wdrop_a,
                     exp16(ra1, 1'b0), exp16(ra2, 1'b0), exp16(ra1, 1'b1), exp16(ra2, 1'b1),
                     left16 > 0, wd16);
         end
         total++;
         if (rd1_c !== exp32(ra1_c) || rd2_c !== exp32(ra2_c) ||
             busy_c !== (left32 > 0) || wdrop_c !== wd32) begin
            bad++;
            $display("FAIL rand32 cyc=%0d rd=%h/%h busy=%b wdrop=%b required %h/%h %b %b",
                     k, rd1_c, rd2_c, busy_c, wdrop_c, exp32(ra1_c), exp32(ra2_c), left32 > 0, wd32);
         end
         tick();
      end
      we3 = 1'b0; clr = 1'b0; we3_c = 1'b0; clr_c = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      clr = 1'b0; we3 = 1'b0; wa3 = '0; wd3 = '0; ra1 = '0; ra2 = '0;
      clr_c = 1'b0; we3_c = 1'b0; wa3_c = '0; wd3_c = '0; ra1_c = '0; ra2_c = '0;
      model_after_reset();
      @(posedge clk); #1;
      test_reset();
      test_write();
      test_bypass();
      test_clear_drop();
      test_reset_abort();
      test_wide();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
